// File: rtl/oled_pkg.sv
// Shared definitions for the OLED framebuffer: address map, CTRL/STATUS bit positions,
// FSM encodings and screen geometry.
// Latency: n/a (package only).  Backpressure: n/a.
package oled_pkg;

  // Address map (byte addresses on the 12-bit CPU bus)
  localparam logic [11:0] FB_BASE     = 12'h000;
  localparam logic [11:0] CTRL_ADDR   = 12'h400;
  localparam logic [11:0] STATUS_ADDR = 12'h404;

  // CTRL / STATUS register fields
  localparam int CTRL_START_BIT  = 0;
  localparam int CTRL_FILL_LSB   = 8;
  localparam int STATUS_BUSY_BIT = 0;

  // Screen geometry: 128 columns x 64 rows, 8 rows per byte (page)
  localparam int SCREEN_COLS  = 128;
  localparam int SCREEN_ROWS  = 64;
  localparam int SCREEN_PAGES = SCREEN_ROWS / 8;
  localparam int SCREEN_BYTES = SCREEN_COLS * SCREEN_PAGES;

  typedef enum logic {
    BUS_IDLE = 1'b0,
    BUS_RESP = 1'b1
  } bus_state_t;

  typedef enum logic {
    FILL_IDLE = 1'b0,
    FILL_RUN  = 1'b1
  } fill_state_t;

  // Framebuffer window is the first KiB of the bus address space
  function automatic logic is_fb_addr(input logic [11:0] addr);
    return addr[11:10] == FB_BASE[11:10];
  endfunction

endpackage

// File: rtl/oled_fb_ram.sv
// Simple dual-port framebuffer RAM: port A 32-bit R/W with byte enables, port B 8-bit read.
// Latency: 1 cycle on both ports; a read colliding with a write returns the old data.
// Backpressure: none, both ports accept an access every cycle.
module oled_fb_ram #(
  parameter int DEPTH_WORDS = 256,
  parameter int AW          = $clog2(DEPTH_WORDS)
) (
  input  logic          clk,
  input  logic          resetn,
  input  logic          a_en,
  input  logic [3:0]    a_we,
  input  logic [AW-1:0] a_addr,
  input  logic [31:0]   a_wdata,
  output logic [31:0]   a_rdata,
  input  logic [AW+1:0] b_addr,
  output logic [7:0]    b_rdata
);

  logic [31:0] mem [DEPTH_WORDS];

  // Port A: byte-lane write plus read-before-write word read
  always_ff @(posedge clk) begin
    if (a_en) begin
      for (int k = 0; k < 4; k++) begin
        if (a_we[k]) begin
          mem[a_addr][8*k +: 8] <= a_wdata[8*k +: 8];
        end
      end
      a_rdata <= mem[a_addr];
    end
  end

  // Port B: screen-side byte read; output register clears on reset so the driver sees 0
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      b_rdata <= 8'h00;
    end else begin
      b_rdata <= mem[b_addr[AW+1:2]][8*b_addr[1:0] +: 8];
    end
  end

endmodule

// File: rtl/oled_framebuffer.sv
// CPU-mapped 1 KiB OLED framebuffer with hardware fill engine and a read-only screen byte port.
// Latency: bus request accepted in T answers with a one-cycle busReady in T+1; screen port 1 cycle.
// Backpressure: framebuffer accesses stall (busReady low) while a fill runs; CSRs never stall.
module oled_framebuffer
  import oled_pkg::*;
#(
  parameter int         DEPTH_WORDS = 256,
  parameter logic [7:0] FILL_RESET  = 8'h00
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        busValid,
  input  logic        busWrite,
  input  logic [11:0] busAddr,
  input  logic [31:0] busWdata,
  input  logic [3:0]  busWstrb,
  output logic        busReady,
  output logic [31:0] busRdata,
  input  logic [9:0]  pixelAddress,
  output logic [7:0]  pixelData
);

  localparam int            AW        = $clog2(DEPTH_WORDS);
  localparam logic [AW-1:0] LAST_WORD = AW'(DEPTH_WORDS - 1);

  bus_state_t    bus_state;
  fill_state_t   fill_state;
  logic [AW-1:0] fill_idx;
  logic [7:0]    fill_reg;
  logic [7:0]    fill_run_byte;
  logic          resp_fb;
  logic [31:0]   csr_rdata;

  logic          addr_fb, addr_ctrl, addr_status;
  logic          accept, fb_req, ctrl_wr, start_req;
  logic [7:0]    next_fill;
  logic [31:0]   csr_rd_val;
  logic          fill_active;

  logic          ram_en;
  logic [3:0]    ram_we;
  logic [AW-1:0] ram_addr;
  logic [31:0]   ram_wdata;
  logic [31:0]   ram_rdata;

  // Byte offset within a word is irrelevant on this bus
  logic unused_addr_lsb;
  assign unused_addr_lsb = ^busAddr[1:0];

  assign addr_fb     = is_fb_addr(busAddr);
  assign addr_ctrl   = busAddr[11:2] == CTRL_ADDR[11:2];
  assign addr_status = busAddr[11:2] == STATUS_ADDR[11:2];
  assign fill_active = fill_state == FILL_RUN;

  // Framebuffer traffic waits for the fill engine to release port A; CSR traffic never waits
  assign accept    = (bus_state == BUS_IDLE) && busValid && (!addr_fb || !fill_active);
  assign fb_req    = accept && addr_fb;
  assign ctrl_wr   = accept && busWrite && addr_ctrl;
  assign start_req = ctrl_wr && busWstrb[0] && busWdata[CTRL_START_BIT];
  // A FILL byte written together with START is the one the fill uses
  assign next_fill = busWstrb[1] ? busWdata[CTRL_FILL_LSB +: 8] : fill_reg;

  // CSR read value, sampled at accept time
  always_comb begin
    csr_rd_val = '0;
    if (addr_ctrl) begin
      csr_rd_val[CTRL_FILL_LSB +: 8] = fill_reg;
    end else if (addr_status) begin
      csr_rd_val[STATUS_BUSY_BIT] = fill_active;
    end
  end

  // Port A mux: the fill engine owns the RAM while running, the bus otherwise
  always_comb begin
    ram_en    = fb_req;
    ram_we    = (fb_req && busWrite) ? busWstrb : 4'h0;
    ram_addr  = busAddr[AW+1:2];
    ram_wdata = busWdata;
    if (fill_active) begin
      ram_en    = 1'b1;
      ram_we    = 4'hF;
      ram_addr  = fill_idx;
      ram_wdata = {4{fill_run_byte}};
    end
  end

  // Fill FSM and CTRL FILL register; the running fill keeps its latched byte
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      fill_state    <= FILL_IDLE;
      fill_idx      <= '0;
      fill_reg      <= FILL_RESET;
      fill_run_byte <= 8'h00;
    end else begin
      if (ctrl_wr && busWstrb[1]) begin
        fill_reg <= busWdata[CTRL_FILL_LSB +: 8];
      end
      case (fill_state)
        FILL_IDLE: begin
          if (start_req) begin
            fill_state    <= FILL_RUN;
            fill_idx      <= '0;
            fill_run_byte <= next_fill;
          end
        end
        FILL_RUN: begin
          if (fill_idx == LAST_WORD) begin
            fill_state <= FILL_IDLE;
          end else begin
            fill_idx <= fill_idx + AW'(1);
          end
        end
        default: fill_state <= FILL_IDLE;
      endcase
    end
  end

  // Bus FSM: one-cycle response after each accepted request, no accept during the response
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      bus_state <= BUS_IDLE;
      busReady  <= 1'b0;
      resp_fb   <= 1'b0;
      csr_rdata <= '0;
    end else begin
      case (bus_state)
        BUS_IDLE: begin
          busReady  <= 1'b0;
          resp_fb   <= 1'b0;
          csr_rdata <= '0;
          if (accept) begin
            bus_state <= BUS_RESP;
            busReady  <= 1'b1;
            resp_fb   <= addr_fb && !busWrite;
            csr_rdata <= busWrite ? 32'h0 : csr_rd_val;
          end
        end
        BUS_RESP: begin
          bus_state <= BUS_IDLE;
          busReady  <= 1'b0;
          resp_fb   <= 1'b0;
          csr_rdata <= '0;
        end
        default: bus_state <= BUS_IDLE;
      endcase
    end
  end

  // Read data only shows while busReady is high; csr_rdata is already zero otherwise
  always_comb begin
    busRdata = csr_rdata;
    if (busReady && resp_fb) begin
      busRdata = ram_rdata;
    end
  end

  oled_fb_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .AW          (AW)
  ) u_ram (
    .clk     (clk),
    .resetn  (resetn),
    .a_en    (ram_en),
    .a_we    (ram_we),
    .a_addr  (ram_addr),
    .a_wdata (ram_wdata),
    .a_rdata (ram_rdata),
    .b_addr  (pixelAddress[AW+1:0]),
    .b_rdata (pixelData)
  );

endmodule

// File: tb/tb_oled_framebuffer.sv
// Self-checking bench for oled_framebuffer: bus read scoreboard plus screen-port byte model.
// Latency: checks the one-cycle bus response, back-to-back spacing and fill stall length.
// Backpressure: bounded waits on busReady; an expired wait is reported as a failed check.
module tb_oled_framebuffer;
  import oled_pkg::*;

  logic        clk = 1'b0;
  logic        resetn;
  logic        busValid;
  logic        busWrite;
  logic [11:0] busAddr;
  logic [31:0] busWdata;
  logic [3:0]  busWstrb;
  logic        busReady;
  logic [31:0] busRdata;
  logic [9:0]  pixelAddress;
  logic [7:0]  pixelData;

  int          n_checks = 0;
  int          n_fail   = 0;
  logic [31:0] exp_q [$];
  logic [7:0]  fbm [1024];

  always #5 clk = ~clk;

  oled_framebuffer dut (
    .clk          (clk),
    .resetn       (resetn),
    .busValid     (busValid),
    .busWrite     (busWrite),
    .busAddr      (busAddr),
    .busWdata     (busWdata),
    .busWstrb     (busWstrb),
    .busReady     (busReady),
    .busRdata     (busRdata),
    .pixelAddress (pixelAddress),
    .pixelData    (pixelData)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // One bus transaction; reads compare against the head of the scoreboard queue
  task automatic bus_xfer(input logic wr, input logic [11:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int exp_lat, input string tag);
    int lat;
    busValid = 1'b1;
    busWrite = wr;
    busAddr  = addr;
    busWdata = wdata;
    busWstrb = strb;
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (!busReady && lat < 2000);
    busValid = 1'b0;
    busWrite = 1'b0;
    busWstrb = 4'h0;
    check_eq({tag, "_ready"}, {31'h0, busReady}, 32'h1);
    if (exp_lat >= 0) check_eq({tag, "_lat"}, lat, exp_lat);
    if (!wr) check_eq({tag, "_rdata"}, busRdata, exp_q.pop_front());
  endtask

  task automatic model_wr(input logic [11:0] addr, input logic [31:0] wdata, input logic [3:0] strb);
    int base;
    base = {22'h0, addr[9:2], 2'b00};
    for (int k = 0; k < 4; k++) begin
      if (strb[k]) fbm[base + k] = wdata[8*k +: 8];
    end
  endtask

  task automatic model_fill(input int words, input logic [7:0] val);
    for (int i = 0; i < 4 * words; i++) fbm[i] = val;
  endtask

  task automatic fb_write(input logic [11:0] addr, input logic [31:0] wdata, input logic [3:0] strb,
                          input int exp_lat, input string tag);
    model_wr(addr, wdata, strb);
    bus_xfer(1'b1, addr, wdata, strb, exp_lat, tag);
  endtask

  task automatic bus_read(input logic [11:0] addr, input logic [31:0] exp, input int exp_lat,
                          input string tag);
    exp_q.push_back(exp);
    bus_xfer(1'b0, addr, 32'h0, 4'h0, exp_lat, tag);
  endtask

  task automatic pixel_check(input logic [9:0] addr, input logic [7:0] exp, input string tag);
    pixelAddress = addr;
    @(posedge clk);
    #1;
    check_eq(tag, {24'h0, pixelData}, {24'h0, exp});
  endtask

  task automatic scan(input string tag);
    for (int i = 0; i < 1024; i++) begin
      pixel_check(10'(i), fbm[i], $sformatf("%s[%0d]", tag, i));
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] px_exp [4];
    px_exp = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    for (int i = 0; i < 1024; i++) fbm[i] = 8'h00;
    resetn       = 1'b0;
    busValid     = 1'b0;
    busWrite     = 1'b0;
    busAddr      = 12'h0;
    busWdata     = 32'h0;
    busWstrb     = 4'h0;
    pixelAddress = 10'h0;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check_eq("rst_ready", {31'h0, busReady}, 32'h0);
    check_eq("rst_rdata", busRdata, 32'h0);
    check_eq("rst_pixel", {24'h0, pixelData}, 32'h0);
    resetn = 1'b1;
    @(posedge clk);
    #1;
    bus_read(STATUS_ADDR, 32'h0, 1, "status_rst");
    bus_read(CTRL_ADDR, 32'h0, 2, "ctrl_rst");

    // Full-word write, single-cycle ready pulse, read-back and screen bytes
    fb_write(12'h010, 32'hDEADBEEF, 4'b1111, 2, "wr10");
    @(posedge clk);
    #1;
    check_eq("ready_pulse", {31'h0, busReady}, 32'h0);
    check_eq("rdata_idle", busRdata, 32'h0);
    bus_read(12'h010, 32'hDEADBEEF, 1, "rd10");
    for (int i = 0; i < 4; i++) pixel_check(10'(16 + i), px_exp[i], $sformatf("px10_%0d", i));

    // Partial strobe merge; low address bits ignored
    fb_write(12'h020, 32'hFFFFFFFF, 4'b1111, 1, "wr20a");
    fb_write(12'h020, 32'h11223344, 4'b0101, 2, "wr20b");
    bus_read(12'h020, 32'hFF22FF44, 2, "rd20");
    bus_read(12'h023, 32'hFF22FF44, 2, "rd23");

    // Fill with FILL and START in the same write; framebuffer write stalls until the fill ends
    bus_xfer(1'b1, CTRL_ADDR, 32'h0000_5501, 4'b0011, 2, "start55");
    model_fill(256, 8'h55);
    fb_write(12'h040, 32'hCAFEF00D, 4'b1111, 257, "wr_in_fill");
    bus_read(CTRL_ADDR, 32'h0000_5500, 2, "ctrl55");
    bus_read(12'h040, 32'hCAFEF00D, 2, "rd40");
    scan("fill55");

    // BUSY, FILL update and START during a run, ignored/unmapped accesses
    bus_xfer(1'b1, CTRL_ADDR, 32'h0000_AA01, 4'b0011, 1, "startAA");
    model_fill(256, 8'hAA);
    bus_read(STATUS_ADDR, 32'h1, 2, "busy_run");
    bus_xfer(1'b1, CTRL_ADDR, 32'h0000_3301, 4'b0011, 2, "start_in_run");
    bus_xfer(1'b1, STATUS_ADDR, 32'hFFFF_FFFF, 4'b1111, 2, "wr_status");
    bus_read(STATUS_ADDR, 32'h1, 2, "busy_after_wr");
    bus_read(12'h800, 32'h0, 2, "rd_unmapped");
    bus_xfer(1'b1, 12'h900, 32'h1234_5678, 4'b1111, 2, "wr_unmapped");
    bus_read(CTRL_ADDR, 32'h0000_3300, 2, "ctrl33");
    repeat (300) @(posedge clk);
    #1;
    bus_read(STATUS_ADDR, 32'h0, 1, "busy_done");
    scan("fillAA");

    // Reset while the fill is at word 100
    bus_xfer(1'b1, CTRL_ADDR, 32'h0000_7701, 4'b0011, 1, "start77");
    model_fill(100, 8'h77);
    repeat (100) @(posedge clk);
    #1;
    resetn = 1'b0;
    #1;
    check_eq("mid_rst_ready", {31'h0, busReady}, 32'h0);
    check_eq("mid_rst_rdata", busRdata, 32'h0);
    check_eq("mid_rst_pixel", {24'h0, pixelData}, 32'h0);
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b1;
    @(posedge clk);
    #1;
    bus_read(STATUS_ADDR, 32'h0, 1, "busy_after_rst");
    bus_read(CTRL_ADDR, 32'h0, 2, "ctrl_after_rst");
    scan("partial");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
